spi_master_ctrl: RTL and testbench

SPI initiator that drives the 8051 SPI data-register peripheral from the other end of the wire. It accepts a byte plus a 2-bit slave select from the CPU-side logic, generates SCK and an active-low slave-select, shifts the byte out on MOSI and captures the returned byte from MISO. The bit order matches the existing shift register: least-significant bit first in both directions. Single mode: SCK idles low, data launched on the falling edge, sampled on the rising edge.

---
 rtl/spi_master_ctrl.sv | 157 +++++++++++++++
 tb/tb_spi_master_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
//
// SPI initiator for the 8051 SPI data-register peripheral. It takes a byte and
// a 2-bit slave index from the CPU side, drives SCK and an active-low slave
// select, shifts the byte out on MOSI and captures the returned byte from MISO.
// Both directions are LSB first. SCK idles low. Data is launched on the falling
// edge and sampled on the rising edge.
//
// Parameters
//   CLKDIV  SCK half-period in CLK cycles (1..255)
//
// Ports
//   CLK     system clock, rising edge
//   RST     asynchronous reset, active high
//   START   transfer request, only looked at while not busy
//   TXDATA  byte to send, latched with START
//   RSEL    slave index, latched with START
//   MISO    serial data from slave
//   SCK     serial clock
//   MOSI    serial data to slave
//   SS_N    one-hot-low slave selects
//   RXDATA  last received byte, updated on DONE
//   BUSY    transfer in progress
//   DONE    one-cycle completion pulse
//
// Build option
//   SPI_LOOPBACK_EN  when defined, the rx sampler takes the internal MOSI value
//                    and the MISO pin is ignored.

module spi_master_ctrl #(
    parameter int CLKDIV = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [7:0] TXDATA,
    input  logic [1:0] RSEL,
    input  logic       MISO,
    output logic       SCK,
    output logic       MOSI,
    output logic [3:0] SS_N,
    output logic [7:0] RXDATA,
    output logic       BUSY,
    output logic       DONE
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        SHIFT  = 3'd2,
        HOLD   = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

    state_t     state;
    logic [7:0] div_cnt;
    logic [3:0] half_cnt;
    logic [7:0] tx_sh;
    logic [7:0] rx_sh;
    logic       tick;
    logic       rx_bit;
    logic       accept;

    // Every state transition out of SETUP/SHIFT/HOLD happens on a tick, and a
    // tick also wraps the counter, so the count is zero on every state entry.
    assign tick   = (div_cnt == DIV_LAST);

    // FINISH accepts START as well so back-to-back bytes lose only one cycle.
    assign accept = START && ((state == IDLE) || (state == FINISH));

`ifdef SPI_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = MISO;
    assign rx_bit      = MOSI;
`else
    // No synchronizer: the slave runs off our SCK, so MISO is stable by the
    // time the rising-edge tick samples it.
    assign rx_bit      = MISO;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            div_cnt  <= '0;
            half_cnt <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            SCK      <= 1'b0;
            MOSI     <= 1'b0;
            SS_N     <= 4'hF;
            RXDATA   <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (tick) div_cnt <= '0;
            else      div_cnt <= div_cnt + 8'd1;

            case (state)
                IDLE, FINISH: begin
                    div_cnt <= '0;
                    if (accept) begin
                        tx_sh    <= TXDATA;
                        rx_sh    <= '0;
                        half_cnt <= '0;
                        SCK      <= 1'b0;
                        MOSI     <= TXDATA[0];
                        SS_N     <= ~(4'b0001 << RSEL);
                        BUSY     <= 1'b1;
                        state    <= SETUP;
                    end else begin
                        state    <= IDLE;
                    end
                end

                SETUP: begin
                    if (tick) state <= SHIFT;
                end

                SHIFT: begin
                    if (tick) begin
                        SCK      <= ~SCK;
                        half_cnt <= half_cnt + 4'd1;
                        if (!SCK) begin
                            // rising edge: new bit enters at the top so the
                            // first bit received ends up in bit 0
                            rx_sh <= {rx_bit, rx_sh[7:1]};
                        end else if (half_cnt != 4'd15) begin
                            // falling edge: launch next bit, except after the
                            // 8th fall where MOSI keeps bit 7
                            tx_sh <= tx_sh >> 1;
                            MOSI  <= tx_sh[1];
                        end
                        if (half_cnt == 4'd15) state <= HOLD;
                    end
                end

                HOLD: begin
                    // one extra half-period of select after the last fall
                    if (tick) begin
                        SS_N   <= 4'hF;
                        MOSI   <= 1'b0;
                        RXDATA <= rx_sh;
                        DONE   <= 1'b1;
                        BUSY   <= 1'b0;
                        state  <= FINISH;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: a CLKDIV=2 instance driven through a scoreboard
// with an LSB-first slave model, plus a CLKDIV=1 instance for back-to-back.

module tb_spi_master_ctrl;

`ifdef SPI_LOOPBACK_EN
    localparam bit LOOPBACK = 1'b1;
`else
    localparam bit LOOPBACK = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic [7:0] TXDATA = 8'h00;
    logic [1:0] RSEL = 2'd0;
    logic       MISO = 1'b0;
    logic       SCK, MOSI, BUSY, DONE;
    logic [3:0] SS_N;
    logic [7:0] RXDATA;

    logic       b_start = 1'b0;
    logic [7:0] b_tx = 8'h00;
    logic [1:0] b_rsel = 2'd0;
    logic       b_miso;
    logic       b_sck, b_mosi, b_busy, b_done;
    logic [3:0] b_ss;
    logic [7:0] b_rx;

    assign b_miso = 1'b1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int e0 = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    spi_master_ctrl #(.CLKDIV(2)) u_dut (
        .CLK(CLK), .RST(RST), .START(START), .TXDATA(TXDATA), .RSEL(RSEL),
        .MISO(MISO), .SCK(SCK), .MOSI(MOSI), .SS_N(SS_N), .RXDATA(RXDATA),
        .BUSY(BUSY), .DONE(DONE)
    );

    spi_master_ctrl #(.CLKDIV(1)) u_b2b (
        .CLK(CLK), .RST(RST), .START(b_start), .TXDATA(b_tx), .RSEL(b_rsel),
        .MISO(b_miso), .SCK(b_sck), .MOSI(b_mosi), .SS_N(b_ss), .RXDATA(b_rx),
        .BUSY(b_busy), .DONE(b_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        logic [3:0] ss;
        int         e0;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       e;
    logic [7:0] slave_byte = 8'h00;
    logic [7:0] mosi_acc = 8'h00;
    int         nrise = 0;
    int         sbit = 0;
    int         n_done = 0;
    logic       sck_q = 1'b0;
    logic [3:0] ss_q = 4'hF;

    // Slave model, MOSI capture and scoreboard pop, all on the falling clock.
    always @(negedge CLK) begin
        if (RST) begin
            nrise    = 0;
            sbit     = 0;
            mosi_acc = 8'h00;
            MISO     = 1'b0;
        end else begin
            if (SS_N != 4'hF && ss_q == 4'hF) begin
                sbit     = 0;
                nrise    = 0;
                mosi_acc = 8'h00;
                MISO     = LOOPBACK ? 1'b0 : slave_byte[0];
            end else if (SS_N != 4'hF && !SCK && sck_q) begin
                sbit++;
                if (sbit < 8) MISO = LOOPBACK ? 1'b0 : slave_byte[sbit];
            end
            if (SCK && !sck_q) begin
                mosi_acc = {MOSI, mosi_acc[7:1]};
                nrise++;
                if (sb_q.size() > 0) chk("ss_at_rise", SS_N, sb_q[0].ss);
            end
            if (DONE) begin
                n_done++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_done_q", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    chk("rxdata", RXDATA, e.rx);
                    chk("mosi_bits", mosi_acc, e.tx);
                    chk("sck_rises", nrise, 8);
                    chk("done_latency", cyc - e.e0, 36);
                    chk("busy_at_done", BUSY, 0);
                    chk("ss_at_done", SS_N, 4'hF);
                    chk("mosi_at_done", MOSI, 0);
                end
            end
        end
        sck_q = SCK;
        ss_q  = SS_N;
    end

    task automatic check_reset_outs();
        chk("rst_sck", SCK, 0);
        chk("rst_mosi", MOSI, 0);
        chk("rst_ss_n", SS_N, 4'hF);
        chk("rst_rxdata", RXDATA, 8'h00);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
    endtask

    task automatic start_xfer(input logic [7:0] tx, input logic [7:0] sl, input logic [1:0] rs);
        exp_t x;
        @(negedge CLK);
        slave_byte = sl;
        START  = 1'b1;
        TXDATA = tx;
        RSEL   = rs;
        x.tx = tx;
        x.rx = LOOPBACK ? tx : sl;
        x.ss = ~(4'b0001 << rs);
        x.e0 = cyc + 1;
        sb_q.push_back(x);
        e0 = x.e0;
        @(negedge CLK);
        START  = 1'b0;
        TXDATA = 8'($urandom);
        RSEL   = 2'($urandom);
        chk("busy_after_e0", BUSY, 1);
        chk("ss_after_e0", SS_N, x.ss);
        chk("mosi_bit0", MOSI, tx[0]);
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (n_done < target && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk("done_timeout", n_done >= target, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int d1, d2, ss_hi;

        // reset with random inputs on the pins
        repeat (3) begin
            @(negedge CLK);
            START  = 1'($urandom);
            TXDATA = 8'($urandom);
            RSEL   = 2'($urandom);
        end
        check_reset_outs();
        @(negedge CLK);
        START = 1'b0;
        RST   = 1'b0;
        repeat (2) @(negedge CLK);

        // single transfer: A5 out, 3C back on slave 2
        start_xfer(8'hA5, 8'h3C, 2'd2);
        wait_done(1, 100);

        // reset mid-idle, RXDATA must clear
        @(negedge CLK);
        RST    = 1'b1;
        START  = 1'($urandom);
        TXDATA = 8'($urandom);
        @(negedge CLK);
        check_reset_outs();
        START = 1'b0;
        RST   = 1'b0;
        @(negedge CLK);

        // busy rejection: stray START with FF at E0+10
        start_xfer(8'hA5, 8'hC3, 2'd2);
        while (cyc < e0 + 9) @(negedge CLK);
        START  = 1'b1;
        TXDATA = 8'hFF;
        @(negedge CLK);
        START  = 1'b0;
        nb = n_done;
        wait_done(nb + 1, 100);
        repeat (40) @(negedge CLK);
        chk("busy_reject_one_done", n_done, nb + 1);

        // abort with RST right after E0+15
        start_xfer(8'h66, 8'h99, 2'd1);
        while (cyc < e0 + 14) @(negedge CLK);
        @(posedge CLK);
        #1 RST = 1'b1;
        #1 check_reset_outs();
        sb_q.delete();
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        nb = n_done;
        repeat (60) @(negedge CLK);
        chk("no_done_after_abort", n_done, nb);
        start_xfer(8'h81, 8'h7E, 2'd3);
        wait_done(nb + 1, 100);

        // a few more patterns across slave indices
        for (int i = 0; i < 3; i++) begin
            nb = n_done;
            start_xfer(8'($urandom), 8'($urandom), (i == 2) ? 2'd3 : 2'(i));
            wait_done(nb + 1, 100);
        end
        chk("sb_drained", sb_q.size(), 0);

        // back-to-back on the CLKDIV=1 instance
        nb = 0; d1 = -1; d2 = -1; ss_hi = 0;
        @(negedge CLK);
        b_start = 1'b1;
        b_tx    = 8'h01;
        b_rsel  = 2'd1;
        e0      = cyc + 1;
        @(negedge CLK);
        b_tx    = 8'h80;
        for (int c = 0; c < 45; c++) begin
            if (b_done) begin
                if (nb == 0) begin
                    d1 = c;
                    chk("b2b_rx1", b_rx, LOOPBACK ? 8'h01 : 8'hFF);
                end else begin
                    d2 = c;
                    chk("b2b_rx2", b_rx, LOOPBACK ? 8'h80 : 8'hFF);
                end
                nb++;
            end
            if (c > 0 && c < 37 && b_ss == 4'hF) ss_hi++;
            if (c == 19) begin
                chk("b2b_setup2_busy", b_busy, 1);
                chk("b2b_setup2_ss", b_ss, 4'b1101);
                b_start = 1'b0;
            end
            @(negedge CLK);
        end
        chk("b2b_done_count", nb, 2);
        chk("b2b_done1_cyc", d1, 18);
        chk("b2b_done2_cyc", d2, 37);
        chk("b2b_ss_gap", ss_hi, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
